// File: rtl/lru_two_victim_ctrl.sv
// lru_two_victim_ctrl
// Requester side of a 2-way LRU bookkeeping port. Accepts one lookup result at a
// time. A hit is resolved in one cycle with an LRU update. A miss reads the
// victim way from the LRU store, issues a refill request with a valid/ready
// handshake, waits for the refill completion pulse, then updates the LRU entry.
// Hit and miss counters saturate at their maximum value.
module lru_two_victim_ctrl #(
    parameter int ENTRIES    = 256,
    parameter int INDEX_BITS = $clog2(ENTRIES),
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [INDEX_BITS-1:0] req_index,
    input  logic                  req_hit,
    input  logic                  req_hit_way,
    output logic [INDEX_BITS-1:0] line_selector,
    input  logic                  lru_way,
    output logic                  lru_update,
    output logic                  referenced_set,
    output logic                  refill_valid,
    input  logic                  refill_ready,
    output logic [INDEX_BITS-1:0] refill_index,
    output logic                  refill_way,
    input  logic                  refill_done,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic                  resp_way,
    input  logic                  clr_stats,
    output logic [CNT_W-1:0]      hit_cnt,
    output logic [CNT_W-1:0]      miss_cnt
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        HIT         = 3'd1,
        VICTIM      = 3'd2,
        REFILL_REQ  = 3'd3,
        REFILL_WAIT = 3'd4,
        DONE        = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [INDEX_BITS-1:0]   index_q;
    logic                    hit_way_q;
    logic                    victim_q;
    logic                    req_ready_q;
    logic                    refill_valid_q;
    logic                    update_q;
    logic                    resp_hit_q;
    logic                    way_q;
    logic [CNT_W-1:0]        hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]        miss_cnt_q, miss_cnt_d;

    // Next-state selection; refill_done only matters while waiting for it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (req_valid) state_d = req_hit ? HIT : VICTIM;
            HIT:         state_d = IDLE;
            VICTIM:      state_d = REFILL_REQ;
            REFILL_REQ:  if (refill_ready) state_d = REFILL_WAIT;
            REFILL_WAIT: if (refill_done) state_d = DONE;
            DONE:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    // FSM state, lookup capture and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            index_q        <= '0;
            hit_way_q      <= 1'b0;
            victim_q       <= 1'b0;
            req_ready_q    <= 1'b1;
            refill_valid_q <= 1'b0;
            update_q       <= 1'b0;
            resp_hit_q     <= 1'b0;
            way_q          <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                index_q   <= req_index;
                hit_way_q <= req_hit_way;
            end
            // The selector has been driving index_q since the accept edge, so
            // the store's combinational victim is valid here.
            if (state_q == VICTIM) begin
                victim_q <= lru_way;
            end
            req_ready_q    <= (state_d == IDLE);
            refill_valid_q <= (state_d == REFILL_REQ);
            update_q       <= (state_d == HIT) || (state_d == DONE);
            resp_hit_q     <= (state_d == HIT);
            // HIT is only entered from an accept, so the incoming way is used directly.
            if (state_d == HIT) begin
                way_q <= req_hit_way;
            end else if (state_d == DONE) begin
                way_q <= victim_q;
            end else begin
                way_q <= 1'b0;
            end
        end
    end

    // Saturating statistics; a clear beats a same-cycle increment.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (clr_stats) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else begin
            if (state_q == HIT && hit_cnt_q != {CNT_W{1'b1}}) begin
                hit_cnt_d = hit_cnt_q + 1'b1;
            end
            if (state_q == DONE && miss_cnt_q != {CNT_W{1'b1}}) begin
                miss_cnt_d = miss_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign line_selector  = index_q;
    assign lru_update     = update_q;
    assign referenced_set = way_q;
    assign refill_valid   = refill_valid_q;
    assign refill_index   = index_q;
    assign refill_way     = victim_q;
    assign resp_valid     = update_q;
    assign resp_hit       = resp_hit_q;
    assign resp_way       = way_q;
    assign hit_cnt        = hit_cnt_q;
    assign miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_lru_two_victim_ctrl.sv
// Testbench for lru_two_victim_ctrl: directed table, reset corner cases,
// counter saturation and randomized lookups against a transaction-level model.
module tb_lru_two_victim_ctrl;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_index;
    logic             req_hit;
    logic             req_hit_way;
    logic [7:0]       line_selector;
    logic             lru_way;
    logic             lru_update;
    logic             referenced_set;
    logic             refill_valid;
    logic             refill_ready;
    logic [7:0]       refill_index;
    logic             refill_way;
    logic             refill_done;
    logic             resp_valid;
    logic             resp_hit;
    logic             resp_way;
    logic             clr_stats;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    always #5 clk = ~clk;

    lru_two_victim_ctrl #(.ENTRIES(256), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
        .req_hit(req_hit), .req_hit_way(req_hit_way),
        .line_selector(line_selector), .lru_way(lru_way),
        .lru_update(lru_update), .referenced_set(referenced_set),
        .refill_valid(refill_valid), .refill_ready(refill_ready),
        .refill_index(refill_index), .refill_way(refill_way), .refill_done(refill_done),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
        .clr_stats(clr_stats), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // LRU store: holds the victim way per set, written on lru_update.
    logic store_mem [0:255];
    assign lru_way = store_mem[line_selector];
    always @(posedge clk) begin
        if (lru_update) store_mem[line_selector] <= ~referenced_set;
    end

    // Reference model: victim per set and expected counter values.
    bit model_lru [0:255];
    int exp_hit, exp_miss;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // One complete lookup; checks cycle-by-cycle behaviour and final counters.
    task automatic lookup(input int idx, input bit hit, input bit way, input int rdy,
                          input int dn, input bit spur, input bit clr, input bit exp_way);
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid   = 1'b1;
        req_index   = idx[7:0];
        req_hit     = hit;
        req_hit_way = hit ? way : 1'($urandom);
        @(negedge clk);
        req_valid   = 1'b0;
        req_index   = 8'($urandom);
        req_hit_way = 1'($urandom);
        chk("req_ready_busy", req_ready, 0);
        chk("line_selector", line_selector, idx);
        if (hit) begin
            clr_stats = clr;
            chk("hit_resp_valid", resp_valid, 1);
            chk("hit_resp_hit", resp_hit, 1);
            chk("hit_resp_way", resp_way, exp_way);
            chk("hit_lru_update", lru_update, 1);
            chk("hit_ref_set", referenced_set, exp_way);
            chk("hit_refill_valid", refill_valid, 0);
            @(negedge clk);
            clr_stats = 1'b0;
            exp_hit   = clr ? 0 : sat_inc(exp_hit);
            if (clr) exp_miss = 0;
        end else begin
            chk("victim_resp_valid", resp_valid, 0);
            chk("victim_refill_valid", refill_valid, 0);
            chk("victim_lru_update", lru_update, 0);
            @(negedge clk);
            chk("refill_valid_t2", refill_valid, 1);
            chk("refill_index", refill_index, idx);
            chk("refill_way", refill_way, exp_way);
            for (int i = 0; i < rdy; i++) begin
                refill_ready = 1'b0;
                @(negedge clk);
                chk("refill_valid_held", refill_valid, 1);
                chk("refill_index_held", refill_index, idx);
                chk("refill_way_held", refill_way, exp_way);
            end
            refill_ready = 1'b1;
            refill_done  = spur;
            @(negedge clk);
            refill_ready = 1'b0;
            refill_done  = 1'b0;
            chk("refill_valid_after_hs", refill_valid, 0);
            for (int i = 0; i < dn - 1; i++) begin
                chk("wait_no_resp", resp_valid, 0);
                @(negedge clk);
            end
            chk("wait_no_resp", resp_valid, 0);
            refill_done = 1'b1;
            @(negedge clk);
            refill_done = 1'b0;
            chk("miss_resp_valid", resp_valid, 1);
            chk("miss_resp_hit", resp_hit, 0);
            chk("miss_resp_way", resp_way, exp_way);
            chk("miss_lru_update", lru_update, 1);
            chk("miss_ref_set", referenced_set, exp_way);
            chk("miss_line_selector", line_selector, idx);
            @(negedge clk);
            exp_miss = sat_inc(exp_miss);
        end
        chk("post_resp_valid", resp_valid, 0);
        chk("post_lru_update", lru_update, 0);
        chk("post_req_ready", req_ready, 1);
        chk("hit_cnt", hit_cnt, exp_hit);
        chk("miss_cnt", miss_cnt, exp_miss);
        model_lru[idx] = ~exp_way;
        $display("[TB] lookup idx=%0d hit=%0d way=%0d hit_cnt=%0d miss_cnt=%0d",
                 idx, hit, exp_way, hit_cnt, miss_cnt);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_refill_valid"}, refill_valid, 0);
        chk({tag, "_lru_update"}, lru_update, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_way"}, resp_way, 0);
        chk({tag, "_ref_set"}, referenced_set, 0);
        chk({tag, "_line_sel"}, line_selector, 0);
        chk({tag, "_hit_cnt"}, hit_cnt, 0);
        chk({tag, "_miss_cnt"}, miss_cnt, 0);
    endtask

    // Start a miss and stop with the request in the refill-request phase.
    task automatic start_miss(input int idx);
        @(negedge clk);
        req_valid = 1'b1;
        req_index = idx[7:0];
        req_hit   = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_refill_valid", refill_valid, 1);
    endtask

    typedef struct {
        int idx;
        bit hit;
        bit way;
        int rdy;
        int dn;
        bit spur;
        bit exp_way;
    } vec_t;

    vec_t vecs [8];

    initial begin
        for (int i = 0; i < 256; i++) begin
            store_mem[i] = 1'b0;
            model_lru[i] = 1'b0;
        end
        rst = 1'b1; req_valid = 0; req_index = 0; req_hit = 0; req_hit_way = 0;
        refill_ready = 0; refill_done = 0; clr_stats = 0;
        exp_hit = 0; exp_miss = 0;

        // Expected ways follow from an all-zero store and the prior table entries.
        vecs[0] = '{idx: 5, hit: 1, way: 1, rdy: 0, dn: 1, spur: 0, exp_way: 1};
        vecs[1] = '{idx: 3, hit: 0, way: 0, rdy: 3, dn: 2, spur: 0, exp_way: 0};
        vecs[2] = '{idx: 7, hit: 0, way: 0, rdy: 0, dn: 1, spur: 1, exp_way: 0};
        vecs[3] = '{idx: 7, hit: 1, way: 0, rdy: 0, dn: 1, spur: 0, exp_way: 0};
        vecs[4] = '{idx: 7, hit: 0, way: 0, rdy: 1, dn: 3, spur: 1, exp_way: 1};
        vecs[5] = '{idx: 3, hit: 0, way: 0, rdy: 2, dn: 1, spur: 0, exp_way: 1};
        vecs[6] = '{idx: 3, hit: 1, way: 1, rdy: 0, dn: 1, spur: 0, exp_way: 1};
        vecs[7] = '{idx: 3, hit: 0, way: 0, rdy: 0, dn: 2, spur: 0, exp_way: 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("init");

        // Reset held two cycles in the middle of a miss.
        start_miss(9);
        rst = 1'b1;
        refill_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("rst_mid");
        rst = 1'b0;
        refill_ready = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_after");

        for (int i = 0; i < 8; i++) begin
            lookup(vecs[i].idx, vecs[i].hit, vecs[i].way, vecs[i].rdy, vecs[i].dn,
                   vecs[i].spur, 1'b0, vecs[i].exp_way);
        end

        // Reset during the refill wait, then a stale completion pulse.
        start_miss(10);
        refill_ready = 1'b1;
        @(negedge clk);
        refill_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        refill_done = 1'b1;
        @(negedge clk);
        refill_done = 1'b0;
        exp_hit = 0; exp_miss = 0;
        chk_reset_outputs("rst_wait");
        @(negedge clk);
        chk_reset_outputs("rst_wait_late");

        // Hit counter saturation, then a clear in a hit cycle.
        for (int i = 0; i < 17; i++) lookup(20, 1'b1, 1'(i), 0, 1, 1'b0, 1'b0, 1'(i));
        chk("hit_cnt_sat", hit_cnt, CMAX);
        lookup(20, 1'b1, 1'b1, 0, 1, 1'b0, 1'b1, 1'b1);
        chk("hit_cnt_clr", hit_cnt, 0);

        // Randomized lookups against the model.
        for (int n = 0; n < 150; n++) begin
            int idx;
            bit hit, way, clr;
            idx = int'($urandom_range(0, 15));
            hit = 1'($urandom);
            way = 1'($urandom);
            clr = hit && ($urandom_range(0, 9) == 0);
            lookup(idx, hit, way, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                   1'($urandom), clr, hit ? way : model_lru[idx]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
